id_ex_stage: RTL

//  Parametrised ID/EX pipeline register with valid/ready flow control and load-use hazard scoreboard.

---
 rtl/id_ex_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready flow control.
// A LOAD_LAT-deep scoreboard tracks recent loads so that a dependent instruction
// waiting in ID stalls until the load result can be forwarded. A saturating
// counter records how many cycles the hazard was raised. Control fields are
// carried through as one opaque bundle. A squashed slot shows up as out_valid=0.
module id_ex_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     RADDR_W   = 5,
  parameter int unsigned     CTRL_W    = 48,
  parameter int unsigned     LOAD_LAT  = 1,
  parameter logic [XLEN-1:0] BUBBLE_PC = {XLEN{1'b1}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [RADDR_W-1:0] in_rs1_addr,
  input  logic [RADDR_W-1:0] in_rs2_addr,
  input  logic               in_rs1_used,
  input  logic               in_rs2_used,
  input  logic [RADDR_W-1:0] in_rd_addr,
  input  logic               in_rd_wen,
  input  logic               in_is_load,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [XLEN-1:0]    out_pc,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [XLEN-1:0]    out_imm,
  output logic [RADDR_W-1:0] out_rs1_addr,
  output logic [RADDR_W-1:0] out_rs2_addr,
  output logic [RADDR_W-1:0] out_rd_addr,
  output logic               out_rd_wen,
  output logic               data_hazard,
  output logic [31:0]        hazard_cycles
);

  // Scoreboard of loads still in flight. Entry 0 mirrors the instruction held in ID/EX.
  // LOAD_LAT is expected to lie in 1..8.
  logic [LOAD_LAT-1:0]              sbValid_q;
  logic [LOAD_LAT-1:0][RADDR_W-1:0] sbRd_q;
  logic                             sbValid_d;

  // Pipeline registers and their next-state values.
  logic               outValid_q,  outValid_d;
  logic [XLEN-1:0]    outPc_q,     outPc_d;
  logic [CTRL_W-1:0]  outCtrl_q,   outCtrl_d;
  logic [XLEN-1:0]    outImm_q,    outImm_d;
  logic [RADDR_W-1:0] outRs1_q,    outRs1_d;
  logic [RADDR_W-1:0] outRs2_q,    outRs2_d;
  logic [RADDR_W-1:0] outRd_q,     outRd_d;
  logic               outRdWen_q,  outRdWen_d;

  logic [31:0]        hazardCount_q, hazardCount_d;

  logic               sbMatch;
  logic               hazard;
  logic               issue;

  // Compare both sources of the ID instruction against every pending load destination.
  always_comb begin
    sbMatch = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (sbValid_q[i] &&
          ((in_rs1_used && (in_rs1_addr == sbRd_q[i])) ||
           (in_rs2_used && (in_rs2_addr == sbRd_q[i])))) begin
        sbMatch = 1'b1;
      end
    end
  end

  // Flush overrides the hazard so a killed instruction never stalls the front end.
  assign hazard   = in_valid & ~flush & sbMatch;
  assign issue    = in_valid & ~flush & out_ready & ~hazard;
  assign in_ready = flush | (out_ready & ~hazard);

  // A slot is recorded in the scoreboard only for loads that really write a nonzero register.
  assign sbValid_d = issue & in_is_load & in_rd_wen & (in_rd_addr != '0);

  // Choose between issuing the ID instruction and inserting a bubble.
  always_comb begin
    outValid_d = issue;
    outRdWen_d = issue & in_rd_wen;
    outPc_d    = issue ? in_pc : BUBBLE_PC;
    outCtrl_d  = in_ctrl;
    outImm_d   = in_imm;
    outRs1_d   = in_rs1_addr;
    outRs2_d   = in_rs2_addr;
    outRd_d    = in_rd_addr;
  end

  // ID/EX register: loads only when execute accepts the current contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      outRdWen_q <= 1'b0;
      outPc_q    <= BUBBLE_PC;
      outCtrl_q  <= '0;
      outImm_q   <= '0;
      outRs1_q   <= '0;
      outRs2_q   <= '0;
      outRd_q    <= '0;
    end else if (out_ready) begin
      outValid_q <= outValid_d;
      outRdWen_q <= outRdWen_d;
      outPc_q    <= outPc_d;
      outCtrl_q  <= outCtrl_d;
      outImm_q   <= outImm_d;
      outRs1_q   <= outRs1_d;
      outRs2_q   <= outRs2_d;
      outRd_q    <= outRd_d;
    end
  end

  // Scoreboard ages in lockstep with the pipeline; the oldest entry simply drops off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbValid_q <= '0;
      sbRd_q    <= '0;
    end else if (out_ready) begin
      for (int i = LOAD_LAT - 1; i > 0; i--) begin
        sbValid_q[i] <= sbValid_q[i-1];
        sbRd_q[i]    <= sbRd_q[i-1];
      end
      sbValid_q[0] <= sbValid_d;
      sbRd_q[0]    <= in_rd_addr;
    end
  end

  // Hazard counter stops at all-ones instead of wrapping.
  always_comb begin
    hazardCount_d = hazardCount_q;
    if (hazard && (hazardCount_q != 32'hFFFF_FFFF)) begin
      hazardCount_d = hazardCount_q + 32'd1;
    end
  end

  // Counter register, advances even while execute holds the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hazardCount_q <= '0;
    end else begin
      hazardCount_q <= hazardCount_d;
    end
  end

  assign out_valid     = outValid_q;
  assign out_pc        = outPc_q;
  assign out_ctrl      = outCtrl_q;
  assign out_imm       = outImm_q;
  assign out_rs1_addr  = outRs1_q;
  assign out_rs2_addr  = outRs2_q;
  assign out_rd_addr   = outRd_q;
  assign out_rd_wen    = outRdWen_q;
  assign data_hazard   = hazard;
  assign hazard_cycles = hazardCount_q;

endmodule
